// File: rtl/space_invaders_pkg.sv
// Shared constants for the space invaders game: alien grid geometry,
// screen limits, the bomb scheduler FSM encoding and a coordinate clamp.
package space_invaders_pkg;

  localparam int N_ROWS        = 3;
  localparam int N_COLS        = 5;
  localparam int ALIEN_WIDTH   = 24;
  localparam int ALIEN_HEIGHT  = 16;
  localparam int X_GAP         = 10;
  localparam int Y_GAP         = 10;
  localparam int SCREEN_BOTTOM = 480;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_PICK   = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_LAUNCH = 2'd3;

  // Screen coordinates are 11-bit; sums are clamped instead of wrapping.
  function automatic logic [10:0] sat_coord(input logic [12:0] v);
    return (v > 13'd2047) ? 11'h7FF : v[10:0];
  endfunction

endpackage

// File: rtl/bomb_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick the firing column.
// The seed is non-zero and the register never reaches the all-zero lock-up state.
module bomb_lfsr16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

  // Shift right, feeding the tap XOR back into the top bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      value <= 16'hACE1;
    else if (enable)
      value <= {feedback, value[15:1]};
  end

endmodule

// File: rtl/alien_bomb_scheduler.sv
// Alien return fire: periodically picks a column, launches a bomb from the
// lowest living alien in it, moves bombs each frame, retires them at the
// screen bottom or on player contact, and draws them for the VGA mux.
module alien_bomb_scheduler
  import space_invaders_pkg::*;
#(
  parameter int          MAX_BOMBS     = 4,
  parameter int          BOMB_W        = 2,
  parameter int          BOMB_H        = 8,
  parameter int          BOMB_SPEED    = 4,
  parameter int          FIRE_INTERVAL = 60,
  parameter int          PLAYER_W      = 32,
  parameter int          PLAYER_H      = 16,
  parameter logic [11:0] BOMB_COLOR    = 12'hFF0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     pause,
  input  logic                     frame_tick,
  input  logic [10:0]              x_offset,
  input  logic [10:0]              y_offset,
  input  logic [N_ROWS*N_COLS-1:0] alive_mask,
  input  logic [10:0]              player_x,
  input  logic [10:0]              player_y,
  input  logic [10:0]              pixel_x,
  input  logic [10:0]              pixel_y,
  output logic                     bomb_on,
  output logic [11:0]              bomb_rgb,
  output logic                     player_hit,
  output logic [3:0]               bombs_active
);

  localparam int COL_W     = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int ROW_W     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int IDX_W     = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;
  localparam int CNT_W     = $clog2(FIRE_INTERVAL + 1);
  localparam int COL_PITCH = ALIEN_WIDTH + X_GAP;
  localparam int ROW_PITCH = ALIEN_HEIGHT + Y_GAP;
  localparam int X_CENTER  = ALIEN_WIDTH / 2 - BOMB_W / 2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     fire_cnt;
  logic [COL_W-1:0]     col;
  logic [COL_W-1:0]     tries;
  logic [ROW_W-1:0]     launch_row;
  logic [15:0]          lfsr_value;

  logic                 col_hit;
  logic [ROW_W-1:0]     col_row;
  logic                 alloc_ok;
  logic [IDX_W-1:0]     alloc_idx;
  logic [10:0]          launch_x;
  logic [10:0]          launch_y;

  logic [MAX_BOMBS-1:0] slot_used;
  logic [10:0]          slot_x  [MAX_BOMBS];
  logic [10:0]          slot_y  [MAX_BOMBS];
  logic [10:0]          moved_y [MAX_BOMBS];
  logic                 retire_pending;
  logic [MAX_BOMBS-1:0] hit_vec;
  logic [MAX_BOMBS-1:0] retire_vec;
  logic                 draw_hit;
  logic [3:0]           used_count;

  bomb_lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (!pause),
    .value   (lfsr_value)
  );

  // Highest living row in the column under inspection (lowest alien on screen).
  always_comb begin
    col_hit = 1'b0;
    col_row = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (alive_mask[r * N_COLS + int'(col)]) begin
        col_hit = 1'b1;
        col_row = ROW_W'(r);
      end
    end
  end

  // Lowest-index free slot, judged on last cycle's occupancy.
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
      if (!slot_used[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign launch_x = sat_coord(13'(x_offset) + 13'(col) * 13'(COL_PITCH) + 13'(X_CENTER));
  assign launch_y = sat_coord(13'(y_offset) + 13'(launch_row) * 13'(ROW_PITCH) + 13'(ALIEN_HEIGHT));

  // Per-slot motion, retirement (bottom or player contact, touching edges count) and pixel coverage.
  always_comb begin
    hit_vec    = '0;
    retire_vec = '0;
    draw_hit   = 1'b0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      moved_y[i] = sat_coord(13'(slot_y[i]) + 13'(BOMB_SPEED));
      if (slot_used[i] &&
          ({1'b0, slot_x[i]} <= {1'b0, player_x} + 12'(PLAYER_W)) &&
          ({1'b0, player_x} <= {1'b0, slot_x[i]} + 12'(BOMB_W)) &&
          ({1'b0, slot_y[i]} <= {1'b0, player_y} + 12'(PLAYER_H)) &&
          ({1'b0, player_y} <= {1'b0, slot_y[i]} + 12'(BOMB_H)))
        hit_vec[i] = 1'b1;
      retire_vec[i] = slot_used[i] && ((slot_y[i] >= 11'(SCREEN_BOTTOM)) || hit_vec[i]);
      if (slot_used[i] &&
          ({1'b0, pixel_x} >= {1'b0, slot_x[i]}) &&
          ({1'b0, pixel_x} <  {1'b0, slot_x[i]} + 12'(BOMB_W)) &&
          ({1'b0, pixel_y} >= {1'b0, slot_y[i]}) &&
          ({1'b0, pixel_y} <  {1'b0, slot_y[i]} + 12'(BOMB_H)))
        draw_hit = 1'b1;
    end
  end

  // Occupied-slot count for the bombs_active register.
  always_comb begin
    used_count = '0;
    for (int i = 0; i < MAX_BOMBS; i++)
      used_count = used_count + {3'b000, slot_used[i]};
  end

  // Fire scheduling FSM: count frames, pick a column, scan for a shooter, launch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_WAIT;
      fire_cnt   <= '0;
      col        <= '0;
      tries      <= '0;
      launch_row <= '0;
    end else if (!pause) begin
      case (state)
        ST_WAIT: begin
          if (frame_tick) begin
            if (fire_cnt == CNT_W'(FIRE_INTERVAL - 1)) begin
              fire_cnt <= '0;
              state    <= ST_PICK;
            end else begin
              fire_cnt <= fire_cnt + 1'b1;
            end
          end
        end
        ST_PICK: begin
          col   <= COL_W'(lfsr_value % 16'(N_COLS));
          tries <= '0;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (col_hit) begin
            launch_row <= col_row;
            state      <= ST_LAUNCH;
          end else if (tries == COL_W'(N_COLS - 1)) begin
            state <= ST_WAIT;
          end else begin
            col   <= (col == COL_W'(N_COLS - 1)) ? '0 : col + 1'b1;
            tries <= tries + 1'b1;
          end
        end
        ST_LAUNCH: state <= ST_WAIT;
        default:   state <= ST_WAIT;
      endcase
    end
  end

  // Slot array: move on tick, retire the cycle after, and take new launches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_used      <= '0;
      retire_pending <= 1'b0;
      player_hit     <= 1'b0;
      for (int i = 0; i < MAX_BOMBS; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
    end else begin
      player_hit <= 1'b0;
      if (!pause) begin
        retire_pending <= frame_tick;
        for (int i = 0; i < MAX_BOMBS; i++) begin
          if (frame_tick && slot_used[i])
            slot_y[i] <= moved_y[i];
          if (retire_pending && retire_vec[i])
            slot_used[i] <= 1'b0;
        end
        if (retire_pending && (|hit_vec))
          player_hit <= 1'b1;
        if ((state == ST_LAUNCH) && alloc_ok) begin
          slot_used[alloc_idx] <= 1'b1;
          slot_x[alloc_idx]    <= launch_x;
          slot_y[alloc_idx]    <= launch_y;
        end
      end
    end
  end

  // Registered pixel output and occupancy count; the draw path ignores pause.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bomb_on      <= 1'b0;
      bomb_rgb     <= '0;
      bombs_active <= '0;
    end else begin
      bomb_on      <= draw_hit;
      bomb_rgb     <= draw_hit ? BOMB_COLOR : 12'h000;
      bombs_active <= used_count;
    end
  end

endmodule

// File: tb/tb_alien_bomb_scheduler.sv
// Randomized self-checking bench for alien_bomb_scheduler. A frame-level
// reference model tracks bombs as plain integers and predicts each frame's
// outcome; draw output is probed pixel by pixel against the model.
module tb_alien_bomb_scheduler;

  localparam int MAXB = 4;
  localparam int FI   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause;
  logic        frame_tick;
  logic [10:0] x_offset, y_offset, player_x, player_y, pixel_x, pixel_y;
  logic [14:0] alive_mask;
  logic        bomb_on;
  logic [11:0] bomb_rgb;
  logic        player_hit;
  logic [3:0]  bombs_active;

  int vectors     = 0;
  int miscompares = 0;
  int hit_seen    = 0;
  int ref_lfsr;
  int launch_col;
  int m_used [MAXB];
  int m_x    [MAXB];
  int m_y    [MAXB];
  int m_fire_cnt;

  always #5 clk = ~clk;

  alien_bomb_scheduler #(.MAX_BOMBS(MAXB), .FIRE_INTERVAL(FI)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pause        (pause),
    .frame_tick   (frame_tick),
    .x_offset     (x_offset),
    .y_offset     (y_offset),
    .alive_mask   (alive_mask),
    .player_x     (player_x),
    .player_y     (player_y),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .bomb_on      (bomb_on),
    .bomb_rgb     (bomb_rgb),
    .player_hit   (player_hit),
    .bombs_active (bombs_active)
  );

  function automatic int lfsrNext(input int l);
    int b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction

  // Reference LFSR stepped on every unpaused clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ref_lfsr = 16'hACE1;
    else if (!pause) ref_lfsr = lfsrNext(ref_lfsr);
  end

  // Count cycles with player_hit asserted.
  always @(negedge clk) if (player_hit === 1'b1) hit_seen++;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int popc();
    int n = 0;
    for (int i = 0; i < MAXB; i++) n += m_used[i];
    return n;
  endfunction

  function automatic int covers(input int px, input int py);
    for (int i = 0; i < MAXB; i++)
      if (m_used[i] != 0 && px >= m_x[i] && px < m_x[i] + 2 && py >= m_y[i] && py < m_y[i] + 8) return 1;
    return 0;
  endfunction

  function automatic int overlaps(input int bx, input int by, input int px, input int py);
    return (bx <= px + 32 && px <= bx + 2 && by <= py + 16 && py <= by + 8) ? 1 : 0;
  endfunction

  function automatic int pickActive();
    int q[$];
    for (int i = 0; i < MAXB; i++) if (m_used[i] != 0) q.push_back(i);
    if (q.size() == 0) return -1;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < MAXB; i++) begin
      m_used[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_fire_cnt = 0;
    launch_col = -1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic probePixel(input string tag, input int px, input int py, input int want_on);
    @(negedge clk);
    pixel_x = 11'(px);
    pixel_y = 11'(py);
    @(negedge clk);
    checkOutput(tag, int'(bomb_on), want_on);
    checkOutput({tag, "_rgb"}, int'(bomb_rgb), (want_on != 0) ? 12'hFF0 : 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_active", int'(bombs_active), 0);
    checkOutput("rst_bomb_on", int'(bomb_on), 0);
    checkOutput("rst_hit", int'(player_hit), 0);
    clearModel();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One video frame: pulse frame_tick, let the scheduler settle, advance the model, compare.
  task automatic applyStimulus(input bit p, input logic [14:0] mask, input int xo, input int yo,
                               input int plx, input int ply, input int n_probes);
    int col0, exp_hit, c, r, slot;
    @(negedge clk);
    pause = p; alive_mask = mask;
    x_offset = 11'(xo); y_offset = 11'(yo);
    player_x = 11'(plx); player_y = 11'(ply);
    frame_tick = 1'b1;
    hit_seen = 0;
    @(posedge clk);
    #1 col0 = ref_lfsr % 5;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (14) @(negedge clk);

    exp_hit = 0;
    if (!p) begin
      for (int i = 0; i < MAXB; i++) begin
        if (m_used[i] != 0) begin
          m_y[i] = clampi(m_y[i] + 4, 0, 2047);
          if (m_y[i] >= 480) m_used[i] = 0;
          else if (overlaps(m_x[i], m_y[i], plx, ply) != 0) begin
            m_used[i] = 0;
            exp_hit = 1;
          end
        end
      end
      if (m_fire_cnt == FI - 1) begin
        m_fire_cnt = 0;
        for (int k = 0; k < 5; k++) begin
          c = (col0 + k) % 5;
          r = -1;
          for (int rr = 0; rr < 3; rr++) if (mask[rr * 5 + c]) r = rr;
          if (r >= 0) begin
            launch_col = c;
            slot = -1;
            for (int s = MAXB - 1; s >= 0; s--) if (m_used[s] == 0) slot = s;
            if (slot >= 0) begin
              m_used[slot] = 1;
              m_x[slot] = clampi(xo + c * 34 + 11, 0, 2047);
              m_y[slot] = clampi(yo + r * 26 + 16, 0, 2047);
            end
            break;
          end
        end
      end else begin
        m_fire_cnt++;
      end
    end

    checkOutput("player_hit", hit_seen, exp_hit);
    checkOutput("bombs_active", int'(bombs_active), popc());
    for (int n = 0; n < n_probes; n++) begin
      int px, py, s;
      s = pickActive();
      if (s >= 0 && $urandom_range(0, 3) != 0) begin
        px = m_x[s] + int'($urandom_range(0, 3)) - 1;
        py = m_y[s] + int'($urandom_range(0, 9)) - 1;
      end else begin
        px = int'($urandom_range(0, 2047));
        py = int'($urandom_range(0, 2047));
      end
      px = clampi(px, 0, 2047);
      py = clampi(py, 0, 2047);
      probePixel("draw", px, py, covers(px, py));
    end
  endtask

  initial begin
    int xo, yo, plx, ply, s;
    logic [14:0] mask;
    bit p;

    reset_n = 1'b0; pause = 1'b0; frame_tick = 1'b0;
    x_offset = '0; y_offset = '0; alive_mask = '0;
    player_x = '0; player_y = '0; pixel_x = '0; pixel_y = '0;
    clearModel();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    checkOutput("reset_active", int'(bombs_active), 0);
    checkOutput("reset_bomb_on", int'(bomb_on), 0);
    checkOutput("reset_rgb", int'(bomb_rgb), 0);
    checkOutput("reset_hit", int'(player_hit), 0);

    // First launch after two ticks, then fill the pool and drop the fifth attempt.
    for (int f = 1; f <= 10; f++) begin
      applyStimulus(1'b0, 15'h7FFF, 100, 80, 1500, 0, 2);
      if (f == 1) checkOutput("t1_pre_active", int'(bombs_active), 0);
      if (f == 2) begin
        checkOutput("t1_active", int'(bombs_active), 1);
        probePixel("t1_top", 100 + launch_col * 34 + 11, 148, 1);
        probePixel("t1_above", 100 + launch_col * 34 + 11, 147, 0);
      end
    end
    checkOutput("t1_full", int'(bombs_active), 4);

    // Empty alien grid never launches.
    pulseReset();
    for (int f = 0; f < 20; f++) applyStimulus(1'b0, 15'h0000, 100, 80, 1500, 0, 1);
    checkOutput("t2_active", int'(bombs_active), 0);

    // Single surviving alien (0,3) fixes the launch point.
    pulseReset();
    applyStimulus(1'b0, 15'h0008, 100, 80, 1500, 0, 0);
    applyStimulus(1'b0, 15'h0008, 100, 80, 1500, 0, 0);
    probePixel("t3_origin", 213, 96, 1);
    probePixel("t3_left", 212, 96, 0);
    probePixel("t3_right", 215, 96, 0);
    probePixel("t3_bottom_in", 214, 103, 1);
    probePixel("t3_bottom_out", 214, 104, 0);
    applyStimulus(1'b0, 15'h0008, 100, 80, 1500, 0, 2);
    applyStimulus(1'b0, 15'h0008, 100, 80, 1500, 0, 2);
    checkOutput("t3_two", int'(bombs_active), 2);

    // Bomb from (2,3) lands on the player one tick after launch.
    pulseReset();
    applyStimulus(1'b0, 15'h2000, 97, 372, 200, 444, 0);
    applyStimulus(1'b0, 15'h2000, 97, 372, 200, 444, 0);
    probePixel("t4_launch", 210, 440, 1);
    applyStimulus(1'b0, 15'h2000, 97, 372, 200, 444, 1);
    checkOutput("t4_hit", hit_seen, 1);
    checkOutput("t4_active", int'(bombs_active), 0);

    // Pause freezes two bombs while the draw path keeps working.
    pulseReset();
    for (int f = 0; f < 4; f++) applyStimulus(1'b0, 15'h7FFF, 300, 60, 1500, 0, 0);
    for (int f = 0; f < 100; f++) applyStimulus(1'b1, 15'h7FFF, 300, 60, 1500, 0, (f % 25 == 0) ? 2 : 0);
    checkOutput("t5_active", int'(bombs_active), 2);
    for (int i = 0; i < MAXB; i++)
      if (m_used[i] != 0) probePixel("t5_bomb", m_x[i], m_y[i], 1);
    pulseReset();
    checkOutput("t5_after_rst", int'(bombs_active), 0);

    // Randomized frames.
    for (int f = 0; f < 250; f++) begin
      if (f == 120) pulseReset();
      p = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       mask = 15'h0000;
        1:       mask = 15'(1 << $urandom_range(0, 14));
        default: mask = 15'($urandom);
      endcase
      xo = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1800, 2047)) : int'($urandom_range(0, 1800));
      yo = ($urandom_range(0, 6) == 0) ? int'($urandom_range(420, 2047)) : int'($urandom_range(0, 420));
      s = pickActive();
      if (s >= 0 && $urandom_range(0, 1) == 1) begin
        plx = clampi(m_x[s] - int'($urandom_range(0, 34)), 0, 2047);
        ply = clampi(m_y[s] + int'($urandom_range(0, 16)) - 10, 0, 460);
      end else begin
        plx = int'($urandom_range(0, 2047));
        ply = int'($urandom_range(0, 460));
      end
      applyStimulus(p, mask, xo, yo, plx, ply, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
